kb_ascii_decoder: RTL

KB_ASCII_DECODER -- requirements
Module: kb_ascii_decoder

---
 rtl/kb_ascii_decoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/kb_ascii_decoder.sv
// rtl/kb_ascii_decoder.sv - PS/2 set-2 scancode to ASCII decoder with output character FIFO
module kb_ascii_decoder #(
  parameter int          DEPTH        = 8,
  parameter bit          DROP_UNKNOWN = 1'b1,
  parameter logic [7:0]  UNKNOWN_CHAR = 8'hFF
) (
  input  logic                     clk,
  input  logic                     i_sclr,
  input  logic [7:0]               i_scancode,
  input  logic                     i_valid,
  output logic [7:0]               o_ascii,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_shift,
  output logic                     o_capslock,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_shift_l, r_shift_r, r_caps, r_caps_held;
  logic          w_shift_l_nxt, w_shift_r_nxt, w_caps_nxt, w_caps_held_nxt;
  logic          w_push;
  logic [7:0]    w_push_data;

  // Map entry layout: {letter, unshifted char, shifted char}; zero means unmapped.
  logic [16:0]   w_map;
  logic          w_map_hit, w_shift, w_sel_hi;
  logic [7:0]    w_map_char;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_pop, w_full, w_wr;

  // Scancode lookup; modifiers applied afterwards from pre-byte state.
  always_comb begin
    w_map = 17'h0;
    case (i_scancode)
      8'h1C: w_map = 17'h1_6141;  8'h32: w_map = 17'h1_6242;  8'h21: w_map = 17'h1_6343;
      8'h23: w_map = 17'h1_6444;  8'h24: w_map = 17'h1_6545;  8'h2B: w_map = 17'h1_6646;
      8'h34: w_map = 17'h1_6747;  8'h33: w_map = 17'h1_6848;  8'h43: w_map = 17'h1_6949;
      8'h3B: w_map = 17'h1_6A4A;  8'h42: w_map = 17'h1_6B4B;  8'h4B: w_map = 17'h1_6C4C;
      8'h3A: w_map = 17'h1_6D4D;  8'h31: w_map = 17'h1_6E4E;  8'h44: w_map = 17'h1_6F4F;
      8'h4D: w_map = 17'h1_7050;  8'h15: w_map = 17'h1_7151;  8'h2D: w_map = 17'h1_7252;
      8'h1B: w_map = 17'h1_7353;  8'h2C: w_map = 17'h1_7454;  8'h3C: w_map = 17'h1_7555;
      8'h2A: w_map = 17'h1_7656;  8'h1D: w_map = 17'h1_7757;  8'h22: w_map = 17'h1_7858;
      8'h35: w_map = 17'h1_7959;  8'h1A: w_map = 17'h1_7A5A;
      8'h16: w_map = 17'h0_3121;  8'h1E: w_map = 17'h0_3222;  8'h26: w_map = 17'h0_3323;
      8'h25: w_map = 17'h0_3424;  8'h2E: w_map = 17'h0_3525;  8'h36: w_map = 17'h0_3626;
      8'h3D: w_map = 17'h0_3727;  8'h3E: w_map = 17'h0_3828;  8'h46: w_map = 17'h0_3929;
      8'h45: w_map = 17'h0_3030;
      8'h4E: w_map = 17'h0_2D3D;  8'h55: w_map = 17'h0_5E7E;  8'h6A: w_map = 17'h0_5C7C;
      8'h54: w_map = 17'h0_4060;  8'h5B: w_map = 17'h0_5B7B;  8'h4C: w_map = 17'h0_3B2B;
      8'h52: w_map = 17'h0_3A2A;  8'h5D: w_map = 17'h0_5D7D;  8'h41: w_map = 17'h0_2C3C;
      8'h49: w_map = 17'h0_2E3E;  8'h4A: w_map = 17'h0_2F3F;
      8'h51: w_map = 17'h0_5F5F;  8'h66: w_map = 17'h0_0808;  8'h5A: w_map = 17'h0_0D0D;
      8'h29: w_map = 17'h0_2020;  8'h76: w_map = 17'h0_1B1B;
      default: w_map = 17'h0;
    endcase
  end

  assign w_shift    = r_shift_l | r_shift_r;
  assign w_map_hit  = (w_map[15:8] != 8'h00);
  assign w_sel_hi   = w_map[16] ? (w_shift ^ r_caps) : w_shift;
  assign w_map_char = w_sel_hi ? w_map[7:0] : w_map[15:8];

  // Parser next-state, modifier updates and push request for the current byte.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_l_nxt   = r_shift_l;
    w_shift_r_nxt   = r_shift_r;
    w_caps_nxt      = r_caps;
    w_caps_held_nxt = r_caps_held;
    w_push          = 1'b0;
    w_push_data     = 8'h00;
    if (i_valid) begin
      case (r_state)
        S_IDLE: begin
          if (i_scancode == 8'hF0) begin
            w_state_nxt = S_BRK;
          end else if (i_scancode == 8'hE0) begin
            w_state_nxt = S_EXT;
          end else if (i_scancode == 8'h12) begin
            w_shift_l_nxt = 1'b1;
          end else if (i_scancode == 8'h59) begin
            w_shift_r_nxt = 1'b1;
          end else if (i_scancode == 8'h58) begin
            // Typematic repeats of caps-lock must not re-toggle.
            if (!r_caps_held) w_caps_nxt = ~r_caps;
            w_caps_held_nxt = 1'b1;
          end else if (w_map_hit) begin
            w_push      = 1'b1;
            w_push_data = w_map_char;
          end else if (DROP_UNKNOWN == 1'b0) begin
            w_push      = 1'b1;
            w_push_data = UNKNOWN_CHAR;
          end
        end
        S_BRK: begin
          if (i_scancode == 8'h12) w_shift_l_nxt = 1'b0;
          if (i_scancode == 8'h59) w_shift_r_nxt = 1'b0;
          if (i_scancode == 8'h58) w_caps_held_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (i_scancode == 8'hF0) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_state_nxt = S_IDLE;
            if (i_scancode == 8'h5A) begin
              w_push      = 1'b1;
              w_push_data = 8'h0D;
            end else if (i_scancode == 8'h4A) begin
              w_push      = 1'b1;
              w_push_data = 8'h2F;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Parser state and modifier registers.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_state     <= S_IDLE;
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift_l   <= w_shift_l_nxt;
      r_shift_r   <= w_shift_r_nxt;
      r_caps      <= w_caps_nxt;
      r_caps_held <= w_caps_held_nxt;
    end
  end

  assign w_pop  = o_valid & i_ready;
  assign w_full = (r_count == CNT_FULL);
  assign w_wr   = w_push & (~w_full | w_pop);

  // Character FIFO: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_valid    = (r_count != '0);
  assign o_ascii    = o_valid ? r_mem[r_rptr] : 8'h00;
  assign o_count    = r_count;
  assign o_shift    = w_shift;
  assign o_capslock = r_caps;
  assign o_overflow = r_overflow;

endmodule
